unframer: RTL and testbench

- Receive-side framing stage placed directly upstream of the de-escaper in the Axi4Stream framing path.
- Takes the raw serial byte stream (no tlast), hunts for unescaped START_BYTE, and strips START/STOP delimiters.
- Forwards payload bytes, escape bytes included, with tlast on the byte preceding STOP.
- Escape removal is left to the downstream de-escaper.

---
 rtl/unframer.sv | 121 ++++++++++++
 tb/tb_unframer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unframer.sv
// Receive-side unframer: hunts for START, strips START/STOP, forwards still-escaped payload
// with tlast on the byte before STOP. Optional abort counter under UNFRAMER_ERR_CNT_EN.
module unframer #(
  parameter logic [7:0] START_BYTE  = 8'h7D,
  parameter logic [7:0] STOP_BYTE   = 8'h7E,
  parameter logic [7:0] ESCAPE_BYTE = 8'h7F
) (
  input  logic        aclk,
  input  logic        aresetn,
`ifdef UNFRAMER_ERR_CNT_EN
  input  logic        err_clear,
  output logic [15:0] err_count,
`endif
  input  logic        target_tvalid,
  output logic        target_tready,
  input  logic [7:0]  target_tdata,
  output logic        initiator_tvalid,
  input  logic        initiator_tready,
  output logic [7:0]  initiator_tdata,
  output logic        initiator_tlast
);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t      state, state_n;
  logic        esc_pending, esc_n;
  logic        hold_valid, hold_valid_n;
  logic [7:0]  hold_data, hold_data_n;
  logic        out_valid, out_valid_n;
  logic [7:0]  out_data, out_data_n;
  logic        out_last, out_last_n;
  logic        accept;
  logic        is_data;
  logic        abort;

  // Ready depends only on registered state and downstream ready, never on target_tvalid.
  assign target_tready = (state == IDLE) || !hold_valid || !out_valid || initiator_tready;
  assign accept        = target_tvalid && target_tready;
  assign is_data       = esc_pending || (target_tdata != STOP_BYTE && target_tdata != START_BYTE);

  assign initiator_tvalid = out_valid;
  assign initiator_tdata  = out_data;
  assign initiator_tlast  = out_last;

  always_comb begin
    state_n      = state;
    esc_n        = esc_pending;
    hold_valid_n = hold_valid;
    hold_data_n  = hold_data;
    out_valid_n  = out_valid && !initiator_tready;
    out_data_n   = out_data;
    out_last_n   = out_last;
    abort        = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (target_tdata == START_BYTE) begin
            state_n = IN_FRAME;
            esc_n   = 1'b0;
          end
        end
        IN_FRAME: begin
          if (is_data) begin
            // The previous held byte is now known not to be last.
            if (hold_valid) begin
              out_valid_n = 1'b1;
              out_data_n  = hold_data;
              out_last_n  = 1'b0;
            end
            hold_data_n  = target_tdata;
            hold_valid_n = 1'b1;
            esc_n        = !esc_pending && (target_tdata == ESCAPE_BYTE);
          end else begin
            // STOP or resync START closes whatever is held; an empty frame emits nothing.
            if (hold_valid) begin
              out_valid_n = 1'b1;
              out_data_n  = hold_data;
              out_last_n  = 1'b1;
            end
            hold_valid_n = 1'b0;
            esc_n        = 1'b0;
            if (target_tdata == STOP_BYTE) state_n = IDLE;
            else                           abort   = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      esc_pending <= 1'b0;
      hold_valid  <= 1'b0;
      hold_data   <= 8'h00;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_last    <= 1'b0;
    end else begin
      state       <= state_n;
      esc_pending <= esc_n;
      hold_valid  <= hold_valid_n;
      hold_data   <= hold_data_n;
      out_valid   <= out_valid_n;
      out_data    <= out_data_n;
      out_last    <= out_last_n;
    end
  end

`ifdef UNFRAMER_ERR_CNT_EN
  always_ff @(posedge aclk) begin
    if (!aresetn || err_clear)          err_count <= 16'h0000;
    else if (abort && err_count != 16'hFFFF) err_count <= err_count + 16'h0001;
  end
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_unframer.sv
// Self-checking bench for unframer: directed test-plan frames plus a randomized stream
// checked against a frame-level reference model.
module tb_unframer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        target_tvalid = 1'b0;
  logic        target_tready;
  logic [7:0]  target_tdata = 8'h00;
  logic        initiator_tvalid;
  logic        initiator_tready = 1'b0;
  logic [7:0]  initiator_tdata;
  logic        initiator_tlast;
`ifdef UNFRAMER_ERR_CNT_EN
  logic        err_clear = 1'b0;
  logic [15:0] err_count;
`endif

  unframer dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
`ifdef UNFRAMER_ERR_CNT_EN
    .err_clear        (err_clear),
    .err_count        (err_count),
`endif
    .target_tvalid    (target_tvalid),
    .target_tready    (target_tready),
    .target_tdata     (target_tdata),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (initiator_tready),
    .initiator_tdata  (initiator_tdata),
    .initiator_tlast  (initiator_tlast)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  logic [7:0] stim_q[$];
  logic [8:0] got_q[$];   // {last, data}
  logic [8:0] exp_q[$];
  int         aborts;
  int         rdy_bad;
  int         last_acc;
  int         timed_out;

  task automatic do_reset(input int cycles);
    @(negedge aclk);
    aresetn       = 1'b0;
    target_tvalid = 1'b0;
    repeat (cycles) @(negedge aclk);
    aresetn = 1'b1;
    #1;
  endtask

  // mode 0: tready=1, 1: tready pattern 1,0,0,1,0,1, 2: random tready and valid gaps, 3: tready=0
  task automatic run_stream(input int mode);
    int idx   = 0;
    int cyc   = 0;
    int flush = 0;
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    got_q.delete();
    rdy_bad   = 0;
    last_acc  = 0;
    timed_out = 0;
    while ((idx < stim_q.size() || flush < 8) && cyc < 5000) begin
      @(negedge aclk);
      cyc++;
      target_tvalid = (idx < stim_q.size()) && (mode != 2 || $urandom_range(3) != 0);
      target_tdata  = target_tvalid ? stim_q[idx] : 8'($urandom);
      if (idx >= stim_q.size()) initiator_tready = (mode != 3);
      else case (mode)
        0:       initiator_tready = 1'b1;
        1:       initiator_tready = pat[(cyc - 1) % 6] != 0;
        2:       initiator_tready = $urandom_range(1) != 0;
        default: initiator_tready = 1'b0;
      endcase
      #1;
      if (target_tvalid && target_tready) begin
        idx++;
        last_acc = cyc;
      end
      if (initiator_tvalid && initiator_tready) got_q.push_back({initiator_tlast, initiator_tdata});
      if (!target_tready && (initiator_tready || !initiator_tvalid)) rdy_bad++;
      if (idx >= stim_q.size()) flush++;
    end
    target_tvalid = 1'b0;
    timed_out = (idx < stim_q.size()) ? 1 : 0;
  endtask

  // Frame-level reference: collect payload per frame, emit it when the frame closes.
  task automatic build_expected();
    bit in_frame = 0;
    bit esc = 0;
    logic [7:0] fr[$];
    logic [7:0] b;
    exp_q.delete();
    aborts = 0;
    foreach (stim_q[i]) begin
      b = stim_q[i];
      if (!in_frame) begin
        if (b == 8'h7D) begin in_frame = 1; esc = 0; fr.delete(); end
      end else if (esc) begin
        fr.push_back(b); esc = 0;
      end else if (b == 8'h7F) begin
        fr.push_back(b); esc = 1;
      end else if (b == 8'h7E || b == 8'h7D) begin
        for (int k = 0; k < fr.size(); k++)
          exp_q.push_back({(k == fr.size() - 1) ? 1'b1 : 1'b0, fr[k]});
        fr.delete();
        if (b == 8'h7E) in_frame = 0;
        else            aborts++;
      end else begin
        fr.push_back(b);
      end
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (initiator_tvalid !== 1'b0 || initiator_tlast !== 1'b0 || initiator_tdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%b d=%h exp v=0 l=0 d=00",
               initiator_tvalid, initiator_tlast, initiator_tdata);
    end
    checks++;
    if (target_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready got=%b exp=1", target_tready);
    end
`ifdef UNFRAMER_ERR_CNT_EN
    checks++;
    if (err_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_err_count got=%h exp=0000", err_count);
    end
`endif
  endtask

  task automatic test_basic();
    stim_q = '{8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E};
    exp_q  = '{9'h001, 9'h002, 9'h103};
    run_stream(0);
    checks++;
    if (timed_out != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got=%0d exp=%0d timeout=%0d", got_q.size(), exp_q.size(), timed_out);
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (last_acc != 5) begin
      errors++;
      $display("FAIL basic_throughput got=%0d exp=5 cycles", last_acc);
    end
  endtask

  task automatic test_escaped();
    stim_q = '{8'h7D, 8'h7F, 8'h7E, 8'h7F, 8'h7D, 8'h7F, 8'h7F, 8'h7E};
    exp_q  = '{9'h07F, 9'h07E, 9'h07F, 9'h07D, 9'h07F, 9'h17F};
    run_stream(0);
    checks++;
    if (timed_out != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL escaped_count got=%0d exp=%0d timeout=%0d", got_q.size(), exp_q.size(), timed_out);
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL escaped_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_garbage_empty();
    stim_q = '{8'h55, 8'h7E, 8'h7F, 8'hAA, 8'h7D, 8'h7E, 8'h7D, 8'h09, 8'h7E};
    exp_q  = '{9'h109};
    run_stream(0);
    checks++;
    if (timed_out != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL garbage_count got=%0d exp=%0d timeout=%0d", got_q.size(), exp_q.size(), timed_out);
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL garbage_beat got=%h exp=%h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_abort();
    do_reset(1);
    stim_q = '{8'h7D, 8'h11, 8'h22, 8'h7D, 8'h33, 8'h7E};
    exp_q  = '{9'h011, 9'h122, 9'h133};
    run_stream(0);
    checks++;
    if (timed_out != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_count got=%0d exp=%0d timeout=%0d", got_q.size(), exp_q.size(), timed_out);
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
`ifdef UNFRAMER_ERR_CNT_EN
    checks++;
    if (err_count !== 16'd1) begin
      errors++;
      $display("FAIL abort_err_count got=%0d exp=1", err_count);
    end
    @(negedge aclk); err_clear = 1'b1;
    @(negedge aclk); err_clear = 1'b0;
    #1;
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL err_clear got=%0d exp=0", err_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    stim_q = '{8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E};
    exp_q  = '{9'h001, 9'h002, 9'h103};
    run_stream(1);
    checks++;
    if (timed_out != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=%0d timeout=%0d", got_q.size(), exp_q.size(), timed_out);
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("FAIL bp_tready got=%0d bad cycles exp=0", rdy_bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    stim_q = '{8'h7D, 8'h01, 8'h02};
    run_stream(3);
    checks++;
    if (initiator_tvalid !== 1'b1 || initiator_tdata !== 8'h01 || initiator_tlast !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_reset got v=%b d=%h l=%b exp v=1 d=01 l=0",
               initiator_tvalid, initiator_tdata, initiator_tlast);
    end
    do_reset(1);
    checks++;
    if (initiator_tvalid !== 1'b0 || initiator_tlast !== 1'b0 || initiator_tdata !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_outputs got v=%b l=%b d=%h exp v=0 l=0 d=00",
               initiator_tvalid, initiator_tlast, initiator_tdata);
    end
    stim_q = '{8'h03, 8'h7E, 8'h7D, 8'h04, 8'h7E};
    exp_q  = '{9'h104};
    run_stream(0);
    checks++;
    if (timed_out != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mid_count got=%0d exp=%0d timeout=%0d", got_q.size(), exp_q.size(), timed_out);
    end else begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL mid_beat got=%h exp=%h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset(1);
    stim_q.delete();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(9);
      case (r)
        0, 1:    stim_q.push_back(8'h7D);
        2:       stim_q.push_back(8'h7E);
        3:       stim_q.push_back(8'h7F);
        default: stim_q.push_back(8'($urandom));
      endcase
    end
    // Two STOPs close any open frame even if an escape is pending.
    stim_q.push_back(8'h7E);
    stim_q.push_back(8'h7E);
    build_expected();
    run_stream(2);
    checks++;
    if (timed_out != 0 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count got=%0d exp=%0d timeout=%0d", got_q.size(), exp_q.size(), timed_out);
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("FAIL random_tready got=%0d bad cycles exp=0", rdy_bad);
    end
`ifdef UNFRAMER_ERR_CNT_EN
    checks++;
    if (err_count !== 16'(aborts)) begin
      errors++;
      $display("FAIL random_err_count got=%0d exp=%0d", err_count, aborts);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_escaped();
    test_garbage_empty();
    test_abort();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
